// File: rtl/multiport_mem_ctrl_if.sv
// Request/response bus of the multiport memory controller.
// Flat per-port vectors: port i uses addr[i*AW +: AW] and wdata[i*DW +: DW].
interface multiport_mem_ctrl_if #(
  parameter int NPORTS = 4,
  parameter int DW     = 16,
  parameter int DEPTH  = 8192
);
  localparam int AW = $clog2(DEPTH);

  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    we;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*DW-1:0] wdata;
  logic [NPORTS-1:0]    gnt;
  logic [NPORTS-1:0]    resp_valid;
  logic [DW-1:0]        rdata;
  logic [1:0]           resp_state;
  logic                 init_done;

  modport master (
    output req, we, addr, wdata,
    input  gnt, resp_valid, rdata, resp_state, init_done
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, resp_valid, rdata, resp_state, init_done
  );
endinterface

// File: rtl/multiport_mem_ctrl.sv
// Multiport memory controller: round-robin arbitration of NPORTS requesters
// onto one DEPTH x DW single-port array, two-stage pipeline, clear-on-reset.
// Optional per-word coherency tracking (I/M/S plus owner) is compiled in when
// the macro MULTIPORT_MEM_COHERENCY_EN is defined; otherwise resp_state is 0.
module multiport_mem_ctrl #(
  parameter int NPORTS = 4,
  parameter int DW     = 16,
  parameter int DEPTH  = 8192
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multiport_mem_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(NPORTS);

  typedef enum logic {INIT, RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  // Per-port views of the flat request buses
  logic [NPORTS-1:0][AW-1:0] addr_a;
  logic [NPORTS-1:0][DW-1:0] wdata_a;
  assign addr_a  = bus.addr;
  assign wdata_a = bus.wdata;

  logic [NPORTS-1:0] gnt;
  logic              gnt_any;
  logic [PW-1:0]     gnt_idx;
  logic [PW:0]       cand;
  logic [PW:0]       nxt;

  // Pipeline: [0] = captured request, [1] = access done, response visible
  logic [1:0]         vld_pipe_q;
  logic [1:0][PW-1:0] port_pipe_q;
  logic               s1_we_q;
  logic [AW-1:0]      s1_addr_q;
  logic [DW-1:0]      s1_wdata_q;
  logic [DW-1:0]      rdata_q;
  logic [NPORTS-1:0]  resp_valid;

  logic [DW-1:0] mem [DEPTH];

  // Next-state for INIT (walks the clear index over every word) -> RUN
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      INIT: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(DEPTH - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= INIT;
      clr_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Round-robin arbiter: scan offsets high to low so the lowest offset from
  // rr_ptr wins; the pointer moves just past the winner.
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    nxt      = '0;
    rr_ptr_d = rr_ptr_q;
    if (reset_n && state_q == RUN) begin
      for (int k = NPORTS - 1; k >= 0; k--) begin
        cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
        if (cand >= (PW+1)'(NPORTS)) cand = cand - (PW+1)'(NPORTS);
        if (bus.req[cand[PW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[PW-1:0];
        end
      end
      if (gnt_any) begin
        gnt[gnt_idx] = 1'b1;
        nxt = {1'b0, gnt_idx} + 1'b1;
        if (nxt == (PW+1)'(NPORTS)) nxt = '0;
        rr_ptr_d = nxt[PW-1:0];
      end
    end
  end

  // Capture the granted request; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe_q  <= '0;
      port_pipe_q <= '0;
      s1_we_q     <= 1'b0;
      s1_addr_q   <= '0;
      s1_wdata_q  <= '0;
    end else begin
      vld_pipe_q  <= {vld_pipe_q[0], gnt_any};
      port_pipe_q <= {port_pipe_q[0], gnt_idx};
      if (gnt_any) begin
        s1_we_q    <= bus.we[gnt_idx];
        s1_addr_q  <= addr_a[gnt_idx];
        s1_wdata_q <= wdata_a[gnt_idx];
      end
    end
  end

  // Single write port: clear sweep during INIT, pipeline writes in RUN
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state_q == INIT) mem[clr_idx_q] <= '0;
      else if (vld_pipe_q[0] && s1_we_q) mem[s1_addr_q] <= s1_wdata_q;
    end
  end

  // Response data: write echoes its data, read returns the stored word
  always_ff @(posedge clk) begin
    if (!reset_n)          rdata_q <= '0;
    else if (vld_pipe_q[0]) rdata_q <= s1_we_q ? s1_wdata_q : mem[s1_addr_q];
    else                   rdata_q <= '0;
  end

  // One-hot response pulse for the port whose access just completed
  always_comb begin
    resp_valid = '0;
    if (vld_pipe_q[1]) resp_valid[port_pipe_q[1]] = 1'b1;
  end

`ifdef MULTIPORT_MEM_COHERENCY_EN
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_M = 2'b01;
  localparam logic [1:0] ST_S = 2'b10;

  logic [1:0]    cst_mem [DEPTH];
  logic [PW-1:0] own_mem [DEPTH];
  logic [1:0]    cur_st;
  logic [1:0]    resp_state_q;

  assign cur_st = cst_mem[s1_addr_q];

  // Coherency transitions at the access edge; the clear sweep resets to I
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state_q == INIT) begin
        cst_mem[clr_idx_q] <= ST_I;
      end else if (vld_pipe_q[0]) begin
        if (s1_we_q) begin
          cst_mem[s1_addr_q] <= ST_M;
          own_mem[s1_addr_q] <= port_pipe_q[0];
        end else if (cur_st == ST_I ||
                     (cur_st == ST_M && own_mem[s1_addr_q] != port_pipe_q[0])) begin
          cst_mem[s1_addr_q] <= ST_S;
        end
      end
    end
  end

  // Report the state the word had before this access
  always_ff @(posedge clk) begin
    if (!reset_n)           resp_state_q <= '0;
    else if (vld_pipe_q[0]) resp_state_q <= cur_st;
    else                    resp_state_q <= '0;
  end

  assign bus.resp_state = resp_state_q;
`else
  assign bus.resp_state = 2'b00;
`endif

  assign bus.gnt        = gnt;
  assign bus.resp_valid = resp_valid;
  assign bus.rdata      = rdata_q;
  assign bus.init_done  = (state_q == RUN);
endmodule

// File: tb/tb_multiport_mem_ctrl.sv
// Self-checking bench for multiport_mem_ctrl (NPORTS=4, DW=16, DEPTH=8192).
// A negedge monitor predicts grants and pushes expected responses at
// acceptance; it pops and compares them when resp_valid fires.
module tb_multiport_mem_ctrl;
  localparam int NP = 4, DW = 16, DEPTH = 8192, AW = 13;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  initial forever #5 clk = ~clk;

  multiport_mem_ctrl_if #(.NPORTS(NP), .DW(DW), .DEPTH(DEPTH)) mif ();

  multiport_mem_ctrl #(.NPORTS(NP), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mif.slave)
  );

  logic [NP-1:0]         req = '0, we = '0;
  logic [NP-1:0][AW-1:0] addr = '0;
  logic [NP-1:0][DW-1:0] wdata = '0;
  assign mif.req   = req;
  assign mif.we    = we;
  assign mif.addr  = addr;
  assign mif.wdata = wdata;

  typedef struct {
    int          port;
    logic [15:0] data;
    logic [1:0]  st;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdl [int];
  logic [1:0]  mst [int];
  int          mown [int];
  int          rr_m = 0;
  int          tests = 0, fails = 0, cyc = 0;

  // Reference memory / coherency model, applied in acceptance order
  task automatic model_access(input int p, input bit w, input int a, input logic [15:0] d,
                              output logic [15:0] ed, output logic [1:0] es);
    ed = w ? d : (mdl.exists(a) ? mdl[a] : 16'h0000);
    if (w) mdl[a] = d;
`ifdef MULTIPORT_MEM_COHERENCY_EN
    es = mst.exists(a) ? mst[a] : 2'b00;
    if (w) begin
      mst[a]  = 2'b01;
      mown[a] = p;
    end else if (es == 2'b00 || (es == 2'b01 && mown[a] != p)) begin
      mst[a] = 2'b10;
    end
`else
    es = 2'b00;
`endif
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: response scoreboard, grant prediction, acceptance capture
  initial forever begin
    exp_t          e;
    logic [NP-1:0] eg, acc, erv;
    logic [15:0]   ed;
    logic [1:0]    es;
    int            idx;
    @(negedge clk);
    tests++;
    if (mif.resp_valid !== '0) begin
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: resp_valid=%b with nothing outstanding", mif.resp_valid);
      end else begin
        e = sb.pop_front();
        erv = '0;
        erv[e.port] = 1'b1;
        if (mif.resp_valid !== erv || mif.rdata !== e.data || mif.resp_state !== e.st || cyc !== e.cyc + 2) begin
          fails++;
          $display("FAIL resp: got rv=%b rdata=%h st=%b cyc=%0d, expected rv=%b rdata=%h st=%b cyc=%0d",
                   mif.resp_valid, mif.rdata, mif.resp_state, cyc, erv, e.data, e.st, e.cyc + 2);
        end
      end
    end else if (mif.rdata !== 16'h0000) begin
      fails++;
      $display("FAIL rdata_idle: got %h, expected 0000", mif.rdata);
    end
    eg = '0;
    if (reset_n && mif.init_done === 1'b1) begin
      for (int k = NP - 1; k >= 0; k--) begin
        idx = (rr_m + k) % NP;
        if (req[idx]) begin
          eg = '0;
          eg[idx] = 1'b1;
        end
      end
    end
    tests++;
    if (mif.gnt !== eg) begin
      fails++;
      $display("FAIL gnt: got %b, expected %b (req=%b rr=%0d)", mif.gnt, eg, req, rr_m);
    end
    if (!reset_n) begin
      sb.delete(); mdl.delete(); mst.delete(); mown.delete();
      rr_m = 0;
    end else begin
      acc = req & mif.gnt;
      for (int p = 0; p < NP; p++) begin
        if (acc[p]) begin
          model_access(p, we[p], int'(addr[p]), wdata[p], ed, es);
          e.port = p; e.data = ed; e.st = es; e.cyc = cyc;
          sb.push_back(e);
          rr_m = (p + 1) % NP;
        end
      end
    end
  end

  // Counts cycles from the last reset edge until init_done; flags any grant
  task automatic wait_init(output int n, output bit gnt_seen);
    gnt_seen = 1'b0;
    for (n = 1; n <= 9000; n++) begin
      @(posedge clk); #1;
      if (mif.init_done === 1'b1) break;
      if (mif.gnt !== '0) gnt_seen = 1'b1;
    end
  endtask

  // Issue one request on port p, wait for grant, sample the response at T+2
  task automatic single_op(input int p, input bit w, input logic [AW-1:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output logic [1:0] rs);
    bit ok = 1'b0;
    @(posedge clk); #1;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (mif.gnt[p] === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL single_op_grant: port %0d never granted", p); end
    @(posedge clk); #1;
    req[p] = 1'b0;
    @(posedge clk); #1;
    rd = mif.rdata; rs = mif.resp_state;
    tests++;
    if (mif.resp_valid[p] !== 1'b1) begin
      fails++;
      $display("FAIL single_op_resp: resp_valid=%b, expected bit %0d set", mif.resp_valid, p);
    end
  endtask

  task automatic test_reset();
    int n; bit gs;
    reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    req = 4'b1000; we = '0; addr[3] = 13'd77; #1;
    tests++;
    if ({mif.gnt, mif.resp_valid, mif.rdata, mif.resp_state, mif.init_done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: gnt=%b rv=%b rdata=%h st=%b init=%b, expected all 0",
               mif.gnt, mif.resp_valid, mif.rdata, mif.resp_state, mif.init_done);
    end
    reset_n = 1'b1;
    repeat (100) @(posedge clk); #1;
    tests++;
    if (mif.init_done !== 1'b0) begin fails++; $display("FAIL init_early: got %b, expected 0", mif.init_done); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_init(n, gs);
    tests++;
    if (n !== 8192) begin fails++; $display("FAIL init_latency: got %0d cycles, expected 8192", n); end
    tests++;
    if (gs) begin fails++; $display("FAIL init_gnt: got a grant during INIT, expected none"); end
    tests++;
    if (mif.gnt !== 4'b1000) begin fails++; $display("FAIL first_run_gnt: got %b, expected 1000", mif.gnt); end
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] eg;
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) addr[p] = AW'(100 + p);
    we = '0; req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      eg = '0; eg[i % NP] = 1'b1;
      tests++;
      if (mif.gnt !== eg) begin fails++; $display("FAIL rr_%0d: got %b, expected %b", i, mif.gnt, eg); end
      @(posedge clk); #1;
    end
    req = '0;
  endtask

  task automatic test_init_zero();
    logic [15:0] rd; logic [1:0] rs;
    logic [AW-1:0] al [3];
    al[0] = 13'd0; al[1] = 13'd8191; al[2] = 13'd4242;
    for (int i = 0; i < 3; i++) begin
      single_op(2, 1'b0, al[i], 16'h0, rd, rs);
      tests++;
      if (rd !== 16'h0000) begin fails++; $display("FAIL init_zero: addr %0d got %h, expected 0000", al[i], rd); end
    end
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 13'd5; wdata[1] = 16'hBEEF; #1;
    tests++;
    if (mif.gnt !== 4'b0010) begin fails++; $display("FAIL wr_gnt: got %b, expected 0010", mif.gnt); end
    @(posedge clk); #1;
    we[1] = 1'b0; #1;
    tests++;
    if (mif.gnt !== 4'b0010) begin fails++; $display("FAIL rd_gnt: got %b, expected 0010", mif.gnt); end
    @(posedge clk); #1;
    req[1] = 1'b0;
    tests++;
    if (mif.resp_valid !== 4'b0010 || mif.rdata !== 16'hBEEF) begin
      fails++; $display("FAIL wr_resp: got rv=%b rdata=%h, expected 0010 beef", mif.resp_valid, mif.rdata);
    end
    @(posedge clk); #1;
    tests++;
    if (mif.resp_valid !== 4'b0010 || mif.rdata !== 16'hBEEF) begin
      fails++; $display("FAIL rd_resp: got rv=%b rdata=%h, expected 0010 beef", mif.resp_valid, mif.rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [NP-1:0] acc = '0;
    int stalls = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 60; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req[p] || acc[p]) begin
          if (c < 55 && $urandom_range(0, 2) != 0) begin
            req[p] = 1'b1; we[p] = 1'($urandom_range(0, 1));
            addr[p] = AW'($urandom_range(0, 15)); wdata[p] = 16'($urandom);
          end else begin
            req[p] = 1'b0;
          end
        end
      end
      #1;
      acc = req & mif.gnt;
      if (req !== '0 && acc === '0) stalls++;
      @(posedge clk); #1;
    end
    req = '0;
    repeat (4) @(posedge clk); #1;
    tests++;
    if (stalls !== 0) begin fails++; $display("FAIL b2b_stall: got %0d idle cycles with requests, expected 0", stalls); end
    tests++;
    if (sb.size() !== 0) begin fails++; $display("FAIL b2b_drain: got %0d outstanding, expected 0", sb.size()); end
  endtask

  task automatic test_coherency();
    logic [15:0] rd; logic [1:0] rs, e1, e2;
`ifdef MULTIPORT_MEM_COHERENCY_EN
    e1 = 2'b01; e2 = 2'b10;
`else
    e1 = 2'b00; e2 = 2'b00;
`endif
    single_op(0, 1'b1, 13'd9, 16'h1234, rd, rs);
    single_op(2, 1'b0, 13'd9, 16'h0, rd, rs);
    tests++;
    if (rs !== e1 || rd !== 16'h1234) begin
      fails++; $display("FAIL coh_read1: got st=%b rdata=%h, expected %b 1234", rs, rd, e1);
    end
    single_op(2, 1'b0, 13'd9, 16'h0, rd, rs);
    tests++;
    if (rs !== e2) begin fails++; $display("FAIL coh_read2: got st=%b, expected %b", rs, e2); end
  endtask

  task automatic test_reset_mid();
    int n; bit gs;
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 13'd20; wdata[0] = 16'hAAAA; #1;
    tests++;
    if (mif.gnt !== 4'b0001) begin fails++; $display("FAIL rst_pre_gnt: got %b, expected 0001", mif.gnt); end
    @(posedge clk); #1;
    req = 4'b0010; we = '0; reset_n = 1'b0; #1;
    tests++;
    if (mif.gnt !== 4'b0000) begin fails++; $display("FAIL rst_gnt: got %b, expected 0000", mif.gnt); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      tests++;
      if (mif.resp_valid !== '0 || mif.gnt !== '0 || mif.init_done !== 1'b0) begin
        fails++; $display("FAIL rst_flush_%0d: got rv=%b gnt=%b init=%b, expected 0 0 0",
                          i, mif.resp_valid, mif.gnt, mif.init_done);
      end
    end
    reset_n = 1'b1; req = 4'b1111;
    wait_init(n, gs);
    tests++;
    if (n !== 8192) begin fails++; $display("FAIL rst_init_latency: got %0d, expected 8192", n); end
    tests++;
    if (mif.gnt !== 4'b0001) begin fails++; $display("FAIL rst_rr_ptr: got gnt %b, expected 0001", mif.gnt); end
    @(posedge clk); #1;
    req = '0;
    repeat (3) @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_init_zero();
    test_write_read();
    test_back_to_back();
    test_coherency();
    test_reset_mid();
    repeat (3) @(posedge clk); #1;
    tests++;
    if (sb.size() !== 0) begin fails++; $display("FAIL final_drain: got %0d outstanding, expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multiport_mem_ctrl.md
MULTIPORT_MEM_CTRL -- requirements
Module: multiport_mem_ctrl

Interface
REQ-001 SHALL have parameter NPORTS, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter DW, default 16, data word width in bits.
REQ-003 SHALL have parameter DEPTH, default 8192, word count; power of two only.
REQ-004 SHALL derive AW = $clog2(DEPTH) and PW = $clog2(NPORTS) locally.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port req  input  NPORTS  per-port request valid.
REQ-008 SHALL have port we  input  NPORTS  per-port write enable; 0 means read.
REQ-009 SHALL have port addr  input  NPORTS*AW  per-port word address; port i uses slice [i*AW +: AW].
REQ-010 SHALL have port wdata  input  NPORTS*DW  per-port write data; port i uses slice [i*DW +: DW].
REQ-011 SHALL have port gnt  output  NPORTS  one-hot grant, combinational from req and priority pointer.
REQ-012 SHALL have port resp_valid  output  NPORTS  one-hot response pulse.
REQ-013 SHALL have port rdata  output  DW  read data, valid while any resp_valid bit is high.
REQ-014 SHALL have port resp_state  output  2  coherency state of the accessed word before the access.
REQ-015 SHALL have port init_done  output  1  high once memory clear completes.

Function
REQ-016 SHALL implement FSM INIT -> RUN; INIT writes word k = 0 (state I) in cycle k, k = 0..DEPTH-1, then enters RUN.
REQ-017 SHALL hold gnt = 0 and init_done = 0 in INIT; init_done = 1 in RUN.
REQ-018 SHALL grant at most one port per cycle in RUN: the first port with req = 1 searching from rr_ptr upward, wrapping modulo NPORTS.
REQ-019 SHALL set rr_ptr = (g + 1) mod NPORTS after granting port g; rr_ptr is unchanged when nothing is granted.
REQ-020 SHALL treat a transaction as accepted in cycle T when req[g] & gnt[g]; the requester holds req/we/addr/wdata stable until then.
REQ-021 SHALL pipeline two stages: capture at edge ending T, array access at edge ending T+1, resp_valid[g] high for exactly cycle T+2.
REQ-022 SHALL sustain one accepted transaction per cycle, completing in acceptance order.
REQ-023 SHALL make a write accepted in T visible to a read accepted in T+1 or later.
REQ-024 SHALL return rdata = written data for writes, memory word for reads; rdata = 0 when no response is pending.
REQ-025 SHALL let port g re-request in T+1; it is granted again only if no other port is requesting.

Reset
REQ-026 SHALL, while reset_n = 0 at a rising edge: gnt = 0, resp_valid = 0, rdata = 0, resp_state = 0, init_done = 0, rr_ptr = 0, FSM = INIT, clear index = 0.
REQ-027 SHALL discard in-flight pipeline transactions on reset, emitting no resp_valid for them.
REQ-028 SHALL restart the full DEPTH-cycle clear when reset is asserted mid-INIT or mid-RUN.

Configuration
REQ-029 SHALL compile, with MULTIPORT_MEM_COHERENCY_EN defined, a per-word 2-bit state (I = 00, M = 01, S = 10) plus a PW-bit owner per word.
REQ-030 SHALL, with the macro: write -> M, owner = g; read of I -> S; read of M by a non-owner -> S; read of M by the owner -> stays M; read of S -> S.
REQ-031 SHALL, without the macro: omit the state and owner arrays and drive resp_state = 2'b00 constantly.

Verification (NPORTS = 4, DW = 16, DEPTH = 8192)
REQ-032 SHALL check: reset released -> init_done rises exactly 8192 cycles later; any read returns 0x0000.
REQ-033 SHALL check: port 1 writes 0xBEEF to addr 5 in T, port 1 reads addr 5 in T+1 -> resp_valid[1] in T+2 and T+3, rdata 0xBEEF in T+3.
REQ-034 SHALL check: req = 4'b1111 held 8 cycles from rr_ptr = 0 -> grants 0,1,2,3,0,1,2,3.
REQ-035 SHALL check, with the macro: port 0 writes addr 9, then port 2 reads addr 9 -> resp_state 01, then port 2 reads again -> resp_state 10.
REQ-036 SHALL check: reset_n low in the cycle after a grant -> no resp_valid, gnt = 0, init_done = 0, rr_ptr = 0.
REQ-037 SHALL check: req = 4'b1000 during INIT -> gnt stays 0 until init_done = 1; granted in the first RUN cycle.
